// File: rtl/uart_rx_if.sv
// Bundle of the serial-receive signals: line input, read strobe, received
// byte with its status flags, and the receiver's current FSM state.
// The master side is the receiver. The slave side is the byte consumer,
// which also drives the serial line.
interface uart_rx_if;
  logic       rx_in;
  logic       ren;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state;

  modport master (
    input  rx_in,
    input  ren,
    output dout,
    output valid,
    output frame_err,
    output overrun,
    output state
  );

  modport slave (
    output rx_in,
    output ren,
    input  dout,
    input  valid,
    input  frame_err,
    input  overrun,
    input  state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The receiver synchronises the serial line and samples
// each bit at mid-bit. It shifts in the data bits LSB first and commits the
// byte to a holding register.
//
// Handshake (valid/ren):
//   - valid=1 means dout holds a byte that has not been read yet.
//   - A cycle with ren=1 and valid=1 consumes the byte. On the next edge,
//     valid and overrun are cleared. A ren while valid=0 is ignored.
//   - The receiver never stalls. A commit while an unread byte is held
//     overwrites dout (newest wins). If the byte was not being read in that
//     same cycle, the commit also sets the sticky overrun flag.
// frame_err pulses for one cycle when the stop bit is sampled low. After
// that, the receiver waits in BREAK until the line returns high, so a held
// low line reports only one error.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1085  // must be >= 4
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    dout_r;
  logic          valid_r;
  logic          frame_err_r;
  logic          overrun_r;

  // Two-flop synchroniser for the asynchronous line. It resets to the idle
  // (high) level so that leaving reset cannot look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM together with the holding register and its flags. The
  // commit and the read share this block because a commit and a read in
  // the same cycle must resolve together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      dout_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;

      // A read consumes the held byte. A commit below in the same cycle
      // overrides valid and leaves overrun cleared.
      if (bus.ren && valid_r) begin
        valid_r   <= 1'b0;
        overrun_r <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        // Recheck the start bit at its midpoint to reject short glitches.
        // This also aligns the later samples to mid-bit.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              dout_r  <= shreg;
              valid_r <= 1'b1;
              if (valid_r && !bus.ren) begin
                overrun_r <= 1'b1;
              end
              state <= S_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.dout      = dout_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. It uses a short bit period to keep the run brief.
// Expected read results come from a byte-level model: the bytes received
// since the last read, plus the last good byte.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters and model ----------------
  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];     // {overrun, dout} expected at each read
  logic [7:0] pend[$];      // good bytes received since the last read
  logic [7:0] last_byte;    // most recent good byte (dout)
  int         fe_seen = 0;
  int         fe_exp  = 0;
  logic       fe_prev = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic drive_bit(input logic v);
    bus.rx_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      pend.push_back(b);
      last_byte = b;
    end else begin
      fe_exp++;
    end
  endtask

  task automatic glitch(input int g);
    bus.rx_in = 1'b0;
    repeat (g) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    idle_bits(1);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_valid"},   bus.valid,   (pend.size() > 0) ? 16'd1 : 16'd0);
    check({tag, "_overrun"}, bus.overrun, (pend.size() > 1) ? 16'd1 : 16'd0);
    check({tag, "_dout"},    bus.dout,    last_byte);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag);
    if (pend.size() > 0) begin
      exp_q.push_back({(pend.size() > 1), pend[pend.size()-1]});
    end
    pend.delete();
    bus.ren = 1'b1;
    @(posedge clk);
    #1;
    bus.ren = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.rx_in = 1'b1;
    bus.ren = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    last_byte = 8'h00;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) begin
        fe_seen++;
        check("frame_err_width", fe_prev, 1'b0);
      end
      fe_prev = bus.frame_err;
      if (bus.ren && bus.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: dout=%0h with no expected byte queued", bus.dout);
        end else begin
          check("read_data", {7'd0, bus.overrun, bus.dout}, {7'd0, exp_q.pop_front()});
        end
      end
    end else begin
      fe_prev = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.rx_in = 1'b1;
    bus.ren = 1'b0;
    last_byte = 8'h00;

    // 1: reset state
    do_reset(3);
    @(negedge clk);
    check("rst_frame_err", bus.frame_err, 1'b0);
    @(posedge clk);
    #1;
    check_state("rst");

    // 2: single "A" then read
    idle_bits(1);
    send_frame(8'h41, 1'b1);
    check_state("a_rx");
    do_read("a_read");
    check("a_no_fe", fe_seen[15:0], fe_exp[15:0]);

    // 3: "A" then "0" back to back, read during the second frame and after it
    send_frame(8'h41, 1'b1);
    fork
      send_frame(8'h30, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        do_read("b2b_read1");
      end
    join
    check_state("b2b_rx");
    do_read("b2b_read2");

    // 4: short glitch, then "A"
    glitch(5);
    check_state("glitch");
    send_frame(8'h41, 1'b1);
    do_read("glitch_a");

    // 5: framing error with held-low line, then "0"
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle_bits(2);
    check("fe_count", fe_seen[15:0], fe_exp[15:0]);
    check_state("fe_hold");
    send_frame(8'h30, 1'b1);
    do_read("fe_then_0");

    // 6: overrun, then reset mid data bit 4
    send_frame(8'h41, 1'b1);
    idle_bits(1);
    send_frame(8'h30, 1'b1);
    check_state("ovr");
    do_read("ovr_read");
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h41 >> i));
    bus.rx_in = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    do_reset(3);
    check_state("mid_rst");
    idle_bits(1);
    send_frame(8'h41, 1'b1);
    do_read("after_rst");

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      if (kind == 0) glitch($urandom_range(1, HALF - 2));
      if (kind == 1) begin
        send_frame(b, 1'b0);
        drive_bit(1'b0);
        idle_bits(1);
      end else begin
        send_frame(b, 1'b1);
      end
      idle_bits($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) do_read("rnd_read");
      check_state("rnd");
    end
    do_read("final_read");

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 16'd0);
    check("fe_total", fe_seen[15:0], fe_exp[15:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
